receive_write_data: RTL

//  Controller-side receiver for cache-to-memory write traffic; the write-direction counterpart of the read-data return path.

---
 rtl/receive_write_data_if.sv | 41 ++++
 rtl/receive_write_data.sv | 126 ++++++++++++
 2 files changed

// File: rtl/receive_write_data_if.sv
// Write-beat ingress, scheduler egress, ack and status signals of the write-data receiver.
// Pure wiring: no storage, no latency of its own.
// Backpressure is carried by wr_ready (toward cache) and sched_ready (from scheduler).
interface receive_write_data_if #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [2:0]        wr_tag;

    logic              sched_valid;
    logic              sched_ready;
    logic [AWIDTH-1:0] sched_addr;
    logic [DWIDTH-1:0] sched_data;
    logic [2:0]        sched_tag;

    logic              ack_valid;
    logic [2:0]        ack_tag;
    logic [LW-1:0]     level;
    logic              tag_err;

    // Cache / scheduler side (drives beats in, consumes the head)
    modport master (
        output wr_valid, wr_addr, wr_data, wr_tag, sched_ready,
        input  wr_ready, sched_valid, sched_addr, sched_data, sched_tag,
        input  ack_valid, ack_tag, level, tag_err
    );

    // Receiver side
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_tag, sched_ready,
        output wr_ready, sched_valid, sched_addr, sched_data, sched_tag,
        output ack_valid, ack_tag, level, tag_err
    );
endinterface

// File: rtl/receive_write_data.sv
// Write-data receiver: buffers cache write beats in a FIFO, hands them in order to the scheduler, acks each pop.
// Latency: a pushed beat appears on sched_* one cycle after acceptance; ack pulses one cycle after its pop.
// Backpressure: wr_ready = ~full (registered, no pass-through on full+pop); sched_ready stalls the head.
// Optional feature macro: WR_TAG_CHECK_EN (drops beats whose tag is already outstanding, pulses tag_err).
module receive_write_data #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    receive_write_data_if.slave   io_bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Storage is intentionally not reset; the pointers define what is valid.
    logic [AWIDTH-1:0] r_mem_addr [DEPTH];
    logic [DWIDTH-1:0] r_mem_data [DEPTH];
    logic [2:0]        r_mem_tag  [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_wr_ready;
    logic          r_ack_valid;
    logic [2:0]    r_ack_tag;

    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_push_hs;
    logic          w_pop;
    logic          w_store;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic          w_full_nxt;
    logic [2:0]    w_head_tag;

    assign w_wr_idx   = r_wr_ptr[IW-1:0];
    assign w_rd_idx   = r_rd_ptr[IW-1:0];
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_head_tag = r_mem_tag[w_rd_idx];

    // r_wr_ready already equals ~full outside reset, so it gates the handshake directly.
    assign w_push_hs = io_bus.wr_valid & r_wr_ready;
    assign w_pop     = ~w_empty & io_bus.sched_ready;

`ifdef WR_TAG_CHECK_EN
    logic [7:0] r_tag_vec;
    logic [7:0] w_tag_vec_nxt;
    logic       w_dup;
    logic       r_tag_err;

    // A tag popped in the same cycle is no longer outstanding, so re-use of it is legal.
    assign w_dup   = w_push_hs & r_tag_vec[io_bus.wr_tag]
                   & ~(w_pop & (w_head_tag == io_bus.wr_tag));
    assign w_store = w_push_hs & ~w_dup;

    // Clear the popped tag first, then set the stored one, so pop T + push T leaves T set.
    always_comb begin
        w_tag_vec_nxt = r_tag_vec;
        if (w_pop)
            w_tag_vec_nxt[w_head_tag] = 1'b0;
        if (w_store)
            w_tag_vec_nxt[io_bus.wr_tag] = 1'b1;
    end

    // Outstanding-tag tracking and the one-cycle drop indication.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tag_vec <= '0;
            r_tag_err <= 1'b0;
        end else begin
            r_tag_vec <= w_tag_vec_nxt;
            r_tag_err <= w_dup;
        end
    end

    assign io_bus.tag_err = r_tag_err;
`else
    assign w_store        = w_push_hs;
    assign io_bus.tag_err = 1'b0;
`endif

    assign w_wr_ptr_nxt = r_wr_ptr + {{(PW-1){1'b0}}, w_store};
    assign w_rd_ptr_nxt = r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
    assign w_full_nxt   = (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1])
                        & (w_wr_ptr_nxt[IW-1:0] == w_rd_ptr_nxt[IW-1:0]);

    // Write the accepted beat into the slot at the write pointer.
    always_ff @(posedge i_clock) begin
        if (w_store) begin
            r_mem_addr[w_wr_idx] <= io_bus.wr_addr;
            r_mem_data[w_wr_idx] <= io_bus.wr_data;
            r_mem_tag[w_wr_idx]  <= io_bus.wr_tag;
        end
    end

    // Pointers, registered ready (from next-state fullness) and the pop acknowledgement.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_ready  <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_tag   <= 3'd0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ready  <= ~w_full_nxt;
            r_ack_valid <= w_pop;
            r_ack_tag   <= w_pop ? w_head_tag : 3'd0;
        end
    end

    assign io_bus.wr_ready    = r_wr_ready;
    assign io_bus.sched_valid = ~w_empty;
    assign io_bus.sched_addr  = w_empty ? '0   : r_mem_addr[w_rd_idx];
    assign io_bus.sched_data  = w_empty ? '0   : r_mem_data[w_rd_idx];
    assign io_bus.sched_tag   = w_empty ? 3'd0 : w_head_tag;
    assign io_bus.ack_valid   = r_ack_valid;
    assign io_bus.ack_tag     = r_ack_tag;
    // Natural-wrap pointer difference is the occupancy, 0..DEPTH.
    assign io_bus.level       = r_wr_ptr - r_rd_ptr;

endmodule
